multi_port_fifo: RTL and testbench
==================================

Name: multi_port_fifo

Overview:
Parametrised multi-lane circular FIFO and the successor to the single-lane fifo. It accepts up to ENQ_LANES entries per cycle and presents up to DEQ_LANES entries per cycle, in program order, with a synchronous flush. It is intended for superscalar front-end queues (fetch to decode, decode to dispatch) in the OOO core. Count is CTR_WIDTH wide so that full is representable.

Parameters:
ENTRY_WIDTH, 32, bits per entry.
N_ENTRIES, 8, depth; must be a power of 2 and at least max(ENQ_LANES, DEQ_LANES).
ENQ_LANES, 2, enqueue lanes per cycle (1..N_ENTRIES).
DEQ_LANES, 2, dequeue lanes per cycle (1..N_ENTRIES).
PTR_WIDTH, $clog2(N_ENTRIES), localparam, entry index width.
CTR_WIDTH, PTR_WIDTH+1, localparam, wrap-bit pointer and occupancy width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_aL  in  1  asynchronous, active-low reset.
flush  in  1  synchronous clear of all contents.
enq_ready  out  ENQ_LANES  bit i = free slots > i.
enq_valid  in  ENQ_LANES  bit i = lane i offers data.
enq_data  in  ENQ_LANES x ENTRY_WIDTH  lane i payload; lane 0 is oldest.
deq_ready  in  DEQ_LANES  bit i = consumer takes lane i.
deq_valid  out  DEQ_LANES  bit i = occupancy > i.
deq_data  out  DEQ_LANES x ENTRY_WIDTH  lane i = entry at deq_ptr+i (mod N_ENTRIES).
count  out  CTR_WIDTH  current occupancy, 0..N_ENTRIES.

Behaviour:
- State: enq_ctr and deq_ctr (CTR_WIDTH each, including the wrap bit), plus N_ENTRIES x ENTRY_WIDTH entry registers.
- Occupancy: count = enq_ctr - deq_ctr (mod 2^CTR_WIDTH). Empty: ctrs equal. Full: low bits equal, MSBs differ.
- Reset (rst_aL=0, asynchronous): ctrs=0, entries=0, count=0, deq_valid=0, deq_data=0, enq_ready=all 1s.
- Enqueue fire is prefix-contiguous: lane i fires iff enq_valid[j] && enq_ready[j] for every j<=i.
- A hole in the enq prefix (e.g. valid=2'b10) stops acceptance at the hole; higher lanes are dropped that cycle, and the producer re-presents them.
- n_enq = number of firing lanes. Lane i writes slot (enq_ptr+i) mod N_ENTRIES. enq_ctr += n_enq.
- Dequeue fire uses the same prefix rule with deq_ready/deq_valid. deq_ctr += n_deq.
- Ready/valid are computed from the current-cycle count only:
  - No same-cycle pass-through of new data to the deq lanes (enq-to-deq latency = 1 cycle).
  - No enqueue into slots freed by a same-cycle dequeue. Full with a simultaneous deq means enq is refused.
- Simultaneous enq and deq when neither is blocked: both apply; count_next = count + n_enq - n_deq.
- Wrap-around: pointers are modulo N_ENTRIES per lane, so a multi-lane write or read may straddle slot N_ENTRIES-1 to slot 0.
- Counters wrap mod 2^CTR_WIDTH. Full/empty stay unambiguous because count never exceeds N_ENTRIES.
- Flush (synchronous):
  - Sets both ctrs to 0 on the next edge.
  - Has priority over same-cycle enq/deq; those fires are discarded. Entry contents need not be cleared.
  - deq_valid=0 the cycle after a flush.
- Reset asserted mid-operation: immediately returns all state and outputs to reset values, independent of clk.
- deq_data lanes with deq_valid=0 are don't-care.
- The block asserts no handshake checks of its own. The bench checks that the producer never drops valid without a fire (not required by design).

Decomposition:
- Shared package: none required. Localparams PTR_WIDTH/CTR_WIDTH stay local.
- Optional helper function: popcount of a prefix mask, defined in the misc helpers include.
- Sub-module add_counter #(WIDTH, MAX_INC):
  - Register with asynchronous active-low reset, a synchronous clear, and an increment of 0..MAX_INC.
  - Instantiated once each for enq_ctr and deq_ctr.
  - Replaces the single-step up_counter.
- Entry storage reuses reg_. Read lanes reuse mux_ with sel = deq_ptr+i.

Test Plan:
- Reset then idle, defaults (8 entries, 2x2 lanes): count=0, enq_ready=2'b11, deq_valid=2'b00 throughout.
- Enq A,B (valid 2'b11) at cycle 1: cycle 2 shows count=2, deq_valid=2'b11, deq_data[0]=A, deq_data[1]=B.
- Fill to 7 then offer 2 lanes: enq_ready=2'b01, only lane 0 accepted, count=8. Next cycle enq_ready=2'b00. A full-cycle enq with deq_ready=2'b01 leaves count=7 and accepts nothing.
- Wrap: 6 enq / 6 deq cycles, then enq X,Y with enq_ptr=7: X lands in slot 7 and Y in slot 0; later deq shows X then Y in order.
- Hole/prefix: enq_valid=2'b10 gives n_enq=0. deq_ready=2'b10 with 2 valid gives n_deq=0, count unchanged.
- Flush with count=5 and a same-cycle enq: next cycle count=0, deq_valid=0. A mid-stream rst_aL low forces count=0 asynchronously before the next edge.

Source files
------------

// File: rtl/multi_port_fifo_pkg.sv
// Shared helpers for the multi-lane FIFO: prefix-contiguous handshake counting.
package multi_port_fifo_pkg;

   // Length of the run of ones starting at bit 0, limited to the first 'lanes' bits.
   function automatic int unsigned prefix_len(input logic [31:0] mask, input int unsigned lanes);
      int unsigned n;
      logic        run;
      n   = 0;
      run = 1'b1;
      for (int unsigned i = 0; i < 32; i++) begin
         if (run && (i < lanes) && mask[i]) n++;
         else run = 1'b0;
      end
      return n;
   endfunction

endpackage

// File: rtl/multi_port_fifo_add_counter.sv
// Counter with async active-low reset, synchronous clear and a 0..MAX_INC increment.
module add_counter #(
   parameter  int unsigned WIDTH   = 4,
   parameter  int unsigned MAX_INC = 2,
   localparam int unsigned INC_W   = $clog2(MAX_INC + 1)
) (
   input  logic             clk,
   input  logic             rst_aL,
   input  logic             clr,
   input  logic [INC_W-1:0] inc,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = clr ? '0 : cnt_q + WIDTH'(inc);
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign q = cnt_q;

endmodule

// File: rtl/multi_port_fifo.sv
// Multi-lane circular FIFO: up to ENQ_LANES writes and DEQ_LANES reads per cycle, in order.
module multi_port_fifo
   import multi_port_fifo_pkg::*;
#(
   parameter  int unsigned ENTRY_WIDTH = 32,
   parameter  int unsigned N_ENTRIES   = 8,
   parameter  int unsigned ENQ_LANES   = 2,
   parameter  int unsigned DEQ_LANES   = 2,
   localparam int unsigned PTR_WIDTH   = $clog2(N_ENTRIES),
   localparam int unsigned CTR_WIDTH   = PTR_WIDTH + 1
) (
   input  logic                             clk,
   input  logic                             rst_aL,
   input  logic                             flush,
   output logic [ENQ_LANES-1:0]             enq_ready,
   input  logic [ENQ_LANES-1:0]             enq_valid,
   input  logic [ENQ_LANES*ENTRY_WIDTH-1:0] enq_data,
   input  logic [DEQ_LANES-1:0]             deq_ready,
   output logic [DEQ_LANES-1:0]             deq_valid,
   output logic [DEQ_LANES*ENTRY_WIDTH-1:0] deq_data,
   output logic [CTR_WIDTH-1:0]             count
);

   localparam int unsigned ENQ_INC_W = $clog2(ENQ_LANES + 1);
   localparam int unsigned DEQ_INC_W = $clog2(DEQ_LANES + 1);

   logic [ENTRY_WIDTH-1:0] mem_q [N_ENTRIES];
   logic [CTR_WIDTH-1:0]   enq_ctr, deq_ctr, free;
   logic [PTR_WIDTH-1:0]   enq_ptr, deq_ptr;
   logic [ENQ_INC_W-1:0]   n_enq;
   logic [DEQ_INC_W-1:0]   n_deq;

   assign enq_ptr = enq_ctr[PTR_WIDTH-1:0];
   assign deq_ptr = deq_ctr[PTR_WIDTH-1:0];
   assign count   = enq_ctr - deq_ctr;

   // Ready/valid look only at the current count: no pass-through, no reuse of same-cycle freed slots.
   always_comb begin
      free = CTR_WIDTH'(N_ENTRIES) - count;
      for (int unsigned i = 0; i < ENQ_LANES; i++) begin
         enq_ready[i] = 32'(free) > i;
      end
      for (int unsigned i = 0; i < DEQ_LANES; i++) begin
         deq_valid[i] = 32'(count) > i;
         deq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] = mem_q[deq_ptr + PTR_WIDTH'(i)];
      end
      n_enq = ENQ_INC_W'(prefix_len(32'(enq_valid & enq_ready), ENQ_LANES));
      n_deq = DEQ_INC_W'(prefix_len(32'(deq_ready & deq_valid), DEQ_LANES));
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         for (int unsigned i = 0; i < N_ENTRIES; i++) mem_q[i] <= '0;
      end else if (!flush) begin
         for (int unsigned i = 0; i < ENQ_LANES; i++) begin
            if (i < 32'(n_enq))
               mem_q[enq_ptr + PTR_WIDTH'(i)] <= enq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
         end
      end
   end

   add_counter #(.WIDTH(CTR_WIDTH), .MAX_INC(ENQ_LANES)) u_enq_ctr (
      .clk    (clk),
      .rst_aL (rst_aL),
      .clr    (flush),
      .inc    (n_enq),
      .q      (enq_ctr)
   );

   add_counter #(.WIDTH(CTR_WIDTH), .MAX_INC(DEQ_LANES)) u_deq_ctr (
      .clk    (clk),
      .rst_aL (rst_aL),
      .clr    (flush),
      .inc    (n_deq),
      .q      (deq_ctr)
   );

endmodule

// File: tb/tb_multi_port_fifo.sv
// Bench for multi_port_fifo (8 entries, 2x2 lanes): queue model checked every cycle plus literal pins.
module tb_multi_port_fifo;

   logic        clk = 1'b0;
   logic        rst_aL;
   logic        flush;
   logic [1:0]  enq_ready, enq_valid, deq_ready, deq_valid;
   logic [63:0] enq_data, deq_data;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;

   logic [31:0] mq [$];

   multi_port_fifo #(.ENTRY_WIDTH(32), .N_ENTRIES(8), .ENQ_LANES(2), .DEQ_LANES(2)) dut (
      .clk       (clk),
      .rst_aL    (rst_aL),
      .flush     (flush),
      .enq_ready (enq_ready),
      .enq_valid (enq_valid),
      .enq_data  (enq_data),
      .deq_ready (deq_ready),
      .deq_valid (deq_valid),
      .deq_data  (deq_data),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: occupancy is the queue size; lanes fire while a contiguous run of handshakes holds.
   always @(negedge clk) begin
      int unsigned sz, ne, nd;
      logic [1:0]  er, dv;
      logic [31:0] dlane;
      if (!rst_aL) begin
         mq.delete();
         chk("rst_count", 64'(count), 64'd0);
         chk("rst_enq_ready", 64'(enq_ready), 64'h3);
         chk("rst_deq_valid", 64'(deq_valid), 64'h0);
         chk("rst_deq_data", deq_data, 64'h0);
      end else begin
         sz = mq.size();
         for (int i = 0; i < 2; i++) begin
            er[i] = (8 - sz) > i;
            dv[i] = sz > i;
         end
         chk("count", 64'(count), 64'(sz));
         chk("enq_ready", 64'(enq_ready), 64'(er));
         chk("deq_valid", 64'(deq_valid), 64'(dv));
         for (int i = 0; i < 2; i++) begin
            if (dv[i]) begin
               dlane = deq_data[i*32 +: 32];
               chk($sformatf("deq_data%0d", i), 64'(dlane), 64'(mq[i]));
            end
         end
         ne = 0;
         while (ne < 2 && enq_valid[ne] && er[ne]) ne++;
         nd = 0;
         while (nd < 2 && deq_ready[nd] && dv[nd]) nd++;
         if (flush) mq.delete();
         else begin
            for (int unsigned i = 0; i < nd; i++) void'(mq.pop_front());
            for (int unsigned i = 0; i < ne; i++) mq.push_back(enq_data[i*32 +: 32]);
         end
      end
   end

   task automatic drive(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] dr, input logic fl);
      @(posedge clk);
      #1;
      enq_valid = ev;
      enq_data  = {d1, d0};
      deq_ready = dr;
      flush     = fl;
   endtask

   typedef struct {
      logic [1:0] ev;
      logic [1:0] dr;
   } vec_t;

   vec_t tbl [12];

   initial begin
      rst_aL    = 1'b0;
      flush     = 1'b0;
      enq_valid = '0;
      enq_data  = '0;
      deq_ready = '0;
      repeat (2) @(posedge clk);
      #1 rst_aL = 1'b1;

      repeat (3) drive(2'b00, 0, 0, 2'b00, 0);
      chk("idle_count", 64'(count), 64'd0);
      chk("idle_enq_ready", 64'(enq_ready), 64'h3);
      chk("idle_deq_valid", 64'(deq_valid), 64'h0);

      drive(2'b11, 32'hA000_000A, 32'hB000_000B, 2'b00, 0);
      drive(2'b00, 0, 0, 2'b00, 0);
      chk("ab_count", 64'(count), 64'd2);
      chk("ab_deq_valid", 64'(deq_valid), 64'h3);
      chk("ab_deq_data", deq_data, {32'hB000_000B, 32'hA000_000A});

      drive(2'b11, 32'h11, 32'h12, 2'b00, 0);
      drive(2'b11, 32'h13, 32'h14, 2'b00, 0);
      drive(2'b01, 32'h15, 32'h0, 2'b00, 0);
      drive(2'b11, 32'hC, 32'hD, 2'b00, 0);
      chk("seven_enq_ready", 64'(enq_ready), 64'h1);
      drive(2'b11, 32'hE, 32'hF, 2'b01, 0);
      chk("full_count", 64'(count), 64'd8);
      chk("full_enq_ready", 64'(enq_ready), 64'h0);
      drive(2'b00, 0, 0, 2'b00, 0);
      chk("full_deq_count", 64'(count), 64'd7);
      chk("full_deq_head", 64'(deq_data[31:0]), 64'hB000_000B);

      repeat (4) drive(2'b00, 0, 0, 2'b11, 0);
      for (int i = 0; i < 7; i++) drive(2'b01, 32'h100 + 32'(i), 0, 2'b01, 0);
      drive(2'b00, 0, 0, 2'b01, 0);
      drive(2'b11, 32'hDEAD_0007, 32'hBEEF_0000, 2'b00, 0);
      drive(2'b00, 0, 0, 2'b00, 0);
      chk("wrap_count", 64'(count), 64'd2);
      chk("wrap_deq_data", deq_data, {32'hBEEF_0000, 32'hDEAD_0007});

      drive(2'b10, 32'h77, 32'h78, 2'b10, 0);
      drive(2'b00, 0, 0, 2'b00, 0);
      chk("hole_count", 64'(count), 64'd2);
      drive(2'b00, 0, 0, 2'b11, 0);
      drive(2'b00, 0, 0, 2'b00, 0);
      chk("drain_count", 64'(count), 64'd0);

      drive(2'b11, 32'h201, 32'h202, 2'b00, 0);
      drive(2'b11, 32'h203, 32'h204, 2'b00, 0);
      drive(2'b01, 32'h205, 32'h0, 2'b00, 0);
      drive(2'b11, 32'h206, 32'h207, 2'b00, 1);
      chk("pre_flush_count", 64'(count), 64'd5);
      drive(2'b00, 0, 0, 2'b00, 0);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_deq_valid", 64'(deq_valid), 64'h0);

      drive(2'b11, 32'h301, 32'h302, 2'b00, 0);
      drive(2'b00, 0, 0, 2'b00, 0);
      @(posedge clk);
      #2 rst_aL = 1'b0;
      #1;
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_deq_valid", 64'(deq_valid), 64'h0);
      chk("async_rst_enq_ready", 64'(enq_ready), 64'h3);
      @(posedge clk);
      #1 rst_aL = 1'b1;

      tbl = '{'{2'b11, 2'b00}, '{2'b01, 2'b01}, '{2'b11, 2'b10}, '{2'b11, 2'b11},
              '{2'b10, 2'b01}, '{2'b11, 2'b00}, '{2'b11, 2'b00}, '{2'b11, 2'b01},
              '{2'b01, 2'b11}, '{2'b00, 2'b11}, '{2'b11, 2'b11}, '{2'b00, 2'b11}};
      foreach (tbl[i]) drive(tbl[i].ev, 32'h400 + 32'(2*i), 32'h401 + 32'(2*i), tbl[i].dr, 0);
      repeat (4) drive(2'b00, 0, 0, 2'b11, 0);
      drive(2'b00, 0, 0, 2'b00, 0);
      @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
